// File: rtl/dma_rx_unpacker_if.sv
// Bus bundle between the PCIe core RX stream, the RX packet buffer and the
// credit-return logic of dma_rx_unpacker.
interface dma_rx_unpacker_if #(
  parameter int DROP_CNT_W = 16
);
  // Handshake: the RX stream is push-only. rx_data is valid on every cycle from
  // rx_st to rx_end inclusive and is never stalled; full is only a drop hint
  // sampled with rx_st. All outputs are one-cycle strobes with no backpressure.
  logic                  rx_st;
  logic                  rx_end;
  logic [15:0]           rx_data;
  logic                  full;

  logic                  rx_dv;
  logic [63:0]           rx_data_out;
  logic                  rx_st_out;
  logic                  rx_end_out;
  logic                  rx_dwen_out;
  logic                  rx_err_out;

  logic                  ph_cr;
  logic                  pd_cr;
  logic [8:0]            pd_num;
  logic                  nph_cr;
  logic                  npd_cr;

  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output rx_st, rx_end, rx_data, full,
    input  rx_dv, rx_data_out, rx_st_out, rx_end_out, rx_dwen_out, rx_err_out,
    input  ph_cr, pd_cr, pd_num, nph_cr, npd_cr, drop_cnt
  );

  modport slave (
    input  rx_st, rx_end, rx_data, full,
    output rx_dv, rx_data_out, rx_st_out, rx_end_out, rx_dwen_out, rx_err_out,
    output ph_cr, pd_cr, pd_num, nph_cr, npd_cr, drop_cnt
  );
endinterface

// File: rtl/dma_rx_unpacker.sv
// Packs the 16-bit PCIe RX TLP stream into tagged 64-bit words for the RX
// buffer and returns ph/pd/nph/npd flow-control credits once each TLP closes.
module dma_rx_unpacker #(
  parameter int DROP_CNT_W = 16
) (
  input  logic               clk_125,
  input  logic               rst,
  dma_rx_unpacker_if.slave   bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic       ph;
    logic       pd;
    logic [8:0] pd_num;
    logic       nph;
    logic       npd;
  } credit_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [63:0]           buf_q, buf_d;
  logic                  first_q, first_d;
  logic [7:0]            hdr_q, hdr_d;
  logic [9:0]            len_q, len_d;
  logic                  have_len_q, have_len_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  dv_q, dv_d;
  logic [63:0]           data_q, data_d;
  logic                  st_q, st_d;
  logic                  end_q, end_d;
  logic                  dwen_q, dwen_d;
  logic                  err_q, err_d;
  credit_t               cr_q, cr_d;

  // Mask keeping the first n beats of a word (beat0 lives in the top bits).
  function automatic logic [63:0] keep_mask(input logic [1:0] n);
    logic [63:0] m;
    case (n)
      2'd0:    m = 64'h0000_0000_0000_0000;
      2'd1:    m = 64'hFFFF_0000_0000_0000;
      2'd2:    m = 64'hFFFF_FFFF_0000_0000;
      default: m = 64'hFFFF_FFFF_FFFF_0000;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] place(input logic [15:0] beat, input logic [1:0] slot);
    logic [5:0] sh;
    sh = {2'd3 - slot, 4'b0000};
    return {48'h0, beat} << sh;
  endfunction

  // hdr is beat0[15:8]: bit 6 is fmt[1] (has data), bits 4:0 the type.
  function automatic credit_t credit_of(input logic [7:0] hdr, input logic [9:0] len,
                                        input logic hdr_only);
    credit_t     c;
    logic [4:0]  ty;
    logic        with_data;
    logic [10:0] sum;
    c         = '0;
    ty        = hdr[4:0];
    with_data = hdr[6];
    sum       = (len == 10'd0) ? 11'd1024 : ({1'b0, len} + 11'd3);
    if (ty[4:3] == 2'b10 || (with_data && ty == 5'b00000)) begin
      c.ph = 1'b1;
      c.pd = with_data && !hdr_only;
      if (c.pd) c.pd_num = sum[10:2];
    end else if (ty == 5'b01010 || ty == 5'b01011) begin
      c = '0;
    end else begin
      c.nph = 1'b1;
      c.npd = with_data && !hdr_only;
    end
    return c;
  endfunction

  always_ff @(posedge clk_125) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      buf_q      <= '0;
      first_q    <= 1'b0;
      hdr_q      <= '0;
      len_q      <= '0;
      have_len_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      first_q    <= first_d;
      hdr_q      <= hdr_d;
      len_q      <= len_d;
      have_len_q <= have_len_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      dv_q   <= 1'b0;
      data_q <= '0;
      st_q   <= 1'b0;
      end_q  <= 1'b0;
      dwen_q <= 1'b0;
      err_q  <= 1'b0;
      cr_q   <= '0;
    end else begin
      dv_q   <= dv_d;
      data_q <= data_d;
      st_q   <= st_d;
      end_q  <= end_d;
      dwen_q <= dwen_d;
      err_q  <= err_d;
      cr_q   <= cr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    first_d    = first_q;
    hdr_d      = hdr_q;
    len_d      = len_q;
    have_len_d = have_len_q;
    drop_d     = drop_q;
    dv_d       = 1'b0;
    data_d     = '0;
    st_d       = 1'b0;
    end_d      = 1'b0;
    dwen_d     = 1'b0;
    err_d      = 1'b0;
    cr_d       = '0;

    // A new rx_st while a TLP is open closes it as malformed: header credit
    // only, and a kept TLP flushes whatever beats it had pending.
    if (state_q != IDLE && bus.rx_st) begin
      cr_d = credit_of(hdr_q, len_q, 1'b1);
      if (state_q == RECV) begin
        dv_d   = 1'b1;
        data_d = buf_q & keep_mask(cnt_q);
        st_d   = first_q;
        end_d  = 1'b1;
        err_d  = 1'b1;
        dwen_d = (cnt_q == 2'd1) || (cnt_q == 2'd2);
      end
    end

    if (bus.rx_st) begin
      hdr_d      = bus.rx_data[15:8];
      len_d      = 10'd1;
      have_len_d = 1'b0;
      first_d    = 1'b1;
      cnt_d      = 2'd1;
      buf_d      = place(bus.rx_data, 2'd0);
      if (bus.full && drop_q != '1) drop_d = drop_q + 1'b1;
      if (bus.rx_end) begin
        // Single-beat TLP: no length field was ever seen.
        state_d = IDLE;
        cnt_d   = 2'd0;
        cr_d    = cr_d | credit_of(bus.rx_data[15:8], 10'd1, 1'b1);
        if (!bus.full) begin
          dv_d   = 1'b1;
          data_d = place(bus.rx_data, 2'd0);
          st_d   = 1'b1;
          end_d  = 1'b1;
          err_d  = 1'b1;
          dwen_d = 1'b1;
        end
      end else begin
        state_d = bus.full ? DROP : RECV;
      end
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 2'd1;
      buf_d = (buf_q & keep_mask(cnt_q)) | place(bus.rx_data, cnt_q);
      if (first_q && cnt_q == 2'd1) begin
        len_d      = bus.rx_data[9:0];
        have_len_d = 1'b1;
      end
      if (cnt_q == 2'd3) first_d = 1'b0;
      if (state_q == RECV && (cnt_q == 2'd3 || bus.rx_end)) begin
        dv_d   = 1'b1;
        data_d = (buf_q & keep_mask(cnt_q)) | place(bus.rx_data, cnt_q);
        st_d   = first_q;
        end_d  = bus.rx_end;
        err_d  = bus.rx_end && !cnt_q[0];
        dwen_d = bus.rx_end && !cnt_q[1];
      end
      if (bus.rx_end) begin
        state_d = IDLE;
        cnt_d   = 2'd0;
        if (first_q && cnt_q == 2'd1)
          cr_d = credit_of(hdr_q, bus.rx_data[9:0], 1'b0);
        else
          cr_d = credit_of(hdr_q, len_q, !have_len_q);
      end
    end
  end

  assign bus.rx_dv       = dv_q;
  assign bus.rx_data_out = data_q;
  assign bus.rx_st_out   = st_q;
  assign bus.rx_end_out  = end_q;
  assign bus.rx_dwen_out = dwen_q;
  assign bus.rx_err_out  = err_q;
  assign bus.ph_cr       = cr_q.ph;
  assign bus.pd_cr       = cr_q.pd;
  assign bus.pd_num      = cr_q.pd_num;
  assign bus.nph_cr      = cr_q.nph;
  assign bus.npd_cr      = cr_q.npd;
  assign bus.drop_cnt    = drop_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_dma_rx_unpacker.sv
// Randomized scoreboard bench for dma_rx_unpacker: a TLP-level model predicts
// packed words and credit pulses, a negedge monitor pops and compares them.
module tb_dma_rx_unpacker;
  localparam int DW = 3;

  logic       clk_125 = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #4 clk_125 = ~clk_125;

  dma_rx_unpacker_if #(.DROP_CNT_W(DW)) bus ();

  dma_rx_unpacker #(.DROP_CNT_W(DW)) dut (
    .clk_125   (clk_125),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  logic [67:0] exp_word_q[$];  // {st, end, dwen, err, data}
  logic [12:0] exp_cr_q[$];    // {ph, pd, pd_num, nph, npd}
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  logic [7:0] kinds[11] = '{8'h40, 8'h60, 8'h00, 8'h20, 8'h4A, 8'h0A,
                            8'h30, 8'h70, 8'h04, 8'h44, 8'h02};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: chunk the TLP's beats into 64-bit words and derive the
  // credit return from the header kind and length.
  task automatic expect_tlp(input logic [15:0] b[$], input bit dropped, input bit with_end);
    int n, nwords, rem, num, len;
    logic [63:0] w;
    logic st, en, dwen, err, fmt1, hdr_only, pd;
    logic [4:0] ty;
    n = b.size();
    if (dropped) begin
      if (exp_drop < (1 << DW) - 1) exp_drop++;
    end else begin
      nwords = with_end ? (n + 3) / 4 : n / 4 + 1;
      for (int j = 0; j < nwords; j++) begin
        w = '0;
        for (int k = 0; k < 4; k++)
          if (4 * j + k < n) w[63 - 16 * k -: 16] = b[4 * j + k];
        rem  = n - 4 * j;
        st   = (j == 0);
        en   = (j == nwords - 1);
        err  = en && (with_end ? (rem == 1 || rem == 3) : 1'b1);
        dwen = en && (rem == 1 || rem == 2);
        exp_word_q.push_back({st, en, dwen, err, w});
      end
    end
    fmt1     = b[0][14];
    ty       = b[0][12:8];
    hdr_only = !with_end || n < 2;
    len      = hdr_only ? 1 : int'(b[1][9:0]);
    num      = (len == 0) ? 256 : (len + 3) / 4;
    pd       = fmt1 && !hdr_only;
    if (ty == 5'b01010 || ty == 5'b01011) begin
      // completions return no credit
    end else if (ty[4:3] == 2'b10 || (fmt1 && ty == 5'b00000)) begin
      exp_cr_q.push_back({1'b1, pd, pd ? 9'(num) : 9'd0, 1'b0, 1'b0});
    end else begin
      exp_cr_q.push_back({1'b0, 1'b0, 9'd0, 1'b1, pd});
    end
  endtask

  task automatic drive(input logic st, input logic en, input logic [15:0] d, input logic f);
    bus.rx_st   = st;
    bus.rx_end  = en;
    bus.rx_data = d;
    bus.full    = f;
    @(posedge clk_125);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'($urandom), 1'($urandom));
  endtask

  task automatic make_tlp(input logic [7:0] hb, input logic [9:0] len, input int n,
                          output logic [15:0] b[$]);
    b.delete();
    b.push_back({hb, 8'($urandom)});
    if (n >= 2) b.push_back({6'($urandom), len});
    for (int i = 2; i < n; i++) b.push_back(16'($urandom));
  endtask

  task automatic send_tlp(input logic [15:0] b[$], input bit full_v, input bit with_end);
    int n;
    n = b.size();
    expect_tlp(b, full_v, with_end);
    for (int i = 0; i < n; i++)
      drive(i == 0, with_end && (i == n - 1), b[i],
            (i == 0) ? full_v : 1'($urandom_range(0, 1)));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dv"},    128'(bus.rx_dv), 128'(0));
    check({tag, "_data"},  128'(bus.rx_data_out), 128'(0));
    check({tag, "_flags"}, 128'({bus.rx_st_out, bus.rx_end_out, bus.rx_dwen_out, bus.rx_err_out}), 128'(0));
    check({tag, "_cr"},    128'({bus.ph_cr, bus.pd_cr, bus.pd_num, bus.nph_cr, bus.npd_cr}), 128'(0));
    check({tag, "_drop"},  128'(bus.drop_cnt), 128'(0));
    check({tag, "_state"}, 128'(dbg_state), 128'(0));
  endtask

  // Monitor: every strobe the DUT presents must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk_125);
      if (bus.rx_dv) begin
        if (exp_word_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected: got %h expected none", bus.rx_data_out);
        end else begin
          check("word", 128'({bus.rx_st_out, bus.rx_end_out, bus.rx_dwen_out, bus.rx_err_out, bus.rx_data_out}),
                128'(exp_word_q.pop_front()));
        end
      end
      if (bus.ph_cr || bus.pd_cr || bus.nph_cr || bus.npd_cr) begin
        if (exp_cr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL credit_unexpected: got %b expected none",
                   {bus.ph_cr, bus.pd_cr, bus.nph_cr, bus.npd_cr});
        end else begin
          check("credit", 128'({bus.ph_cr, bus.pd_cr, bus.pd_cr ? bus.pd_num : 9'd0, bus.nph_cr, bus.npd_cr}),
                128'(exp_cr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [15:0] b[$];
    logic [7:0]  hb;
    logic [9:0]  len;
    int          n;
    bit          full_v, with_end, term_prev;

    rst = 1'b1;
    bus.rx_st = 1'b0;
    bus.rx_end = 1'b0;
    bus.rx_data = '0;
    bus.full = 1'b0;
    repeat (3) @(posedge clk_125);
    #1;
    rst = 1'b0;
    check_quiet("reset");

    // MWr32 length 1, 8 beats
    make_tlp(8'h40, 10'd1, 8, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(2);
    // MRd32 length 16, 6 beats
    make_tlp(8'h00, 10'd16, 6, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(2);
    // MWr length 0 while full
    make_tlp(8'h40, 10'd0, 8, b);
    send_tlp(b, 1'b1, 1'b1);
    check("drop_after_full", 128'(bus.drop_cnt), 128'(exp_drop));
    idle(2);
    // CplD then MWr back to back
    make_tlp(8'h4A, 10'd2, 8, b);
    send_tlp(b, 1'b0, 1'b1);
    make_tlp(8'h40, 10'd5, 10, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(2);
    // end at beat count 2
    make_tlp(8'h00, 10'd3, 7, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(2);

    // reset at beat 3 of an MWr
    make_tlp(8'h40, 10'd4, 8, b);
    drive(1'b1, 1'b0, b[0], 1'b0);
    drive(1'b0, 1'b0, b[1], 1'b0);
    drive(1'b0, 1'b0, b[2], 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, b[3], 1'b0);
    exp_drop = 0;
    check_quiet("midrst");
    rst = 1'b0;
    idle(1);
    make_tlp(8'h40, 10'd4, 8, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(2);

    // single-beat TLP, then a TLP cut short by the next rx_st
    make_tlp(8'h40, 10'd9, 1, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(1);
    make_tlp(8'h40, 10'd9, 6, b);
    send_tlp(b, 1'b0, 1'b0);
    make_tlp(8'h00, 10'd2, 4, b);
    send_tlp(b, 1'b0, 1'b1);
    idle(2);

    term_prev = 1'b0;
    for (int t = 0; t < 60; t++) begin
      hb       = kinds[$urandom_range(0, 10)];
      n        = term_prev ? $urandom_range(2, 14) : $urandom_range(1, 14);
      full_v   = ($urandom_range(0, 3) == 0);
      with_end = (t == 59) || ($urandom_range(0, 5) != 0);
      len      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 8));
      make_tlp(hb, len, n, b);
      send_tlp(b, full_v, with_end);
      check("drop_cnt", 128'(bus.drop_cnt), 128'(exp_drop));
      term_prev = !with_end;
      if (with_end) idle($urandom_range(0, 2));
    end

    idle(6);
    check("words_left", 128'(exp_word_q.size()), 128'(0));
    check("credits_left", 128'(exp_cr_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
